scene_reader: RTL

- Read side of the scene memory that `scene_generator` fills.
- Turns VGA raster coordinates into tile reads and returns the tile type plus the pixel offset inside the tile, aligned for the renderer.
- Time-multiplexes the same read port for a player-logic collision query port, served only outside active video.
- Sits between scene memory, the VGA timing block and the player/collision logic.

---
 rtl/scene_pkg.sv | 30 +++
 rtl/scene_query_fsm.sv | 68 ++++++
 rtl/scene_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/scene_pkg.sv
// scene_pkg: tile codes, scene geometry and the tile address function
// shared by scene_generator and scene_reader.
package scene_pkg;

  typedef enum logic [1:0] {
    BACKGROUND = 2'd0,
    BLOCK      = 2'd1,
    CACTUS     = 2'd2,
    COIN       = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_ADDR = 2'd1,
    Q_WAIT = 2'd2,
    Q_CAP  = 2'd3
  } q_state_t;

  localparam int SCENE_BLOCK_WIDTH  = 20;
  localparam int SCENE_BLOCK_HEIGHT = 15;
  localparam int TILE_SHIFT         = 5;

  // Row-major tile address, ty*20 + tx built from shifts; largest value is 299.
  function automatic logic [8:0] tile_addr(input logic [4:0] tx, input logic [3:0] ty);
    logic [8:0] ty_w;
    ty_w = {5'b0, ty};
    return (ty_w << 4) + (ty_w << 2) + {4'b0, tx};
  endfunction

endpackage

// File: rtl/scene_query_fsm.sv
// scene_query_fsm: collision query state machine sharing the scene memory
// read port with the raster. It only owns the port during blanking, and an
// active-video start aborts any query in flight. Used when
// SCENE_READER_QUERY_EN is defined; otherwise the top ties its request off.
module scene_query_fsm #(
  parameter int SCENE_BLOCK_WIDTH  = scene_pkg::SCENE_BLOCK_WIDTH,
  parameter int SCENE_BLOCK_HEIGHT = scene_pkg::SCENE_BLOCK_HEIGHT,
  parameter int ADDR_W             = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              generate_done,
  input  logic              pix_active,
  input  logic              q_req,
  input  logic [4:0]        q_tx,
  input  logic [3:0]        q_ty,
  input  logic [1:0]        mem_data,
  output logic              q_grant,
  output logic [ADDR_W-1:0] q_addr,
  output logic              q_ack,
  output logic [1:0]        q_tile
);
  import scene_pkg::*;

  q_state_t state;
  logic     out_of_range;
  logic     serviceable;

  assign out_of_range = (32'(q_tx) >= SCENE_BLOCK_WIDTH) || (32'(q_ty) >= SCENE_BLOCK_HEIGHT);
  assign serviceable  = q_req && generate_done && !pix_active;
  assign q_grant      = !pix_active;

  // Query sequencing: latch address, wait out the memory latency, capture and ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= Q_IDLE;
      q_addr <= '0;
      q_ack  <= 1'b0;
      q_tile <= BACKGROUND;
    end else begin
      q_ack <= 1'b0;
      case (state)
        Q_IDLE: begin
          if (serviceable) begin
            if (out_of_range) begin
              q_tile <= BLOCK;
              q_ack  <= 1'b1;
            end else begin
              q_addr <= ADDR_W'(tile_addr(q_tx, q_ty));
              state  <= Q_ADDR;
            end
          end
        end
        Q_ADDR: state <= pix_active ? Q_IDLE : Q_WAIT;
        Q_WAIT: state <= pix_active ? Q_IDLE : Q_CAP;
        Q_CAP: begin
          if (!pix_active) begin
            q_tile <= mem_data;
            q_ack  <= 1'b1;
          end
          state <= Q_IDLE;
        end
        default: state <= Q_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scene_reader.sv
// scene_reader: converts VGA raster coordinates into scene memory reads and
// delivers tile code plus in-tile offsets three cycles later. With
// SCENE_READER_QUERY_EN defined, a collision query port borrows the memory
// port during blanking; otherwise the raster always drives mem_addr.
module scene_reader #(
  parameter int SCENE_BLOCK_WIDTH  = scene_pkg::SCENE_BLOCK_WIDTH,
  parameter int SCENE_BLOCK_HEIGHT = scene_pkg::SCENE_BLOCK_HEIGHT,
  parameter int TILE_SHIFT         = scene_pkg::TILE_SHIFT,
  parameter int ADDR_W             = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              generate_done,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_active,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic [1:0]        pix_tile,
  output logic [4:0]        pix_off_x,
  output logic [4:0]        pix_off_y,
  output logic              pix_valid,
  input  logic              q_req,
  input  logic [4:0]        q_tx,
  input  logic [3:0]        q_ty,
  output logic              q_ack,
  output logic [1:0]        q_tile
);
  import scene_pkg::*;

  logic [ADDR_W-1:0] raster_addr;
  logic [4:0]        off_x1, off_y1, off_x2, off_y2;
  logic              valid1, valid2;

  logic              fsm_req;
  logic [4:0]        fsm_tx;
  logic [3:0]        fsm_ty;
  logic              fsm_grant;
  logic [ADDR_W-1:0] fsm_addr;
  logic              fsm_ack;
  logic [1:0]        fsm_tile;
  logic              query_owns;
  logic              unused_bits;

  assign raster_addr = ADDR_W'(tile_addr(pix_x[TILE_SHIFT +: 5], pix_y[TILE_SHIFT +: 4]));

`ifdef SCENE_READER_QUERY_EN
  assign fsm_req     = q_req;
  assign fsm_tx      = q_tx;
  assign fsm_ty      = q_ty;
  assign query_owns  = fsm_grant;
  assign q_ack       = fsm_ack;
  assign q_tile      = fsm_tile;
  assign unused_bits = pix_y[9];
`else
  assign fsm_req     = 1'b0;
  assign fsm_tx      = '0;
  assign fsm_ty      = '0;
  assign query_owns  = 1'b0;
  assign q_ack       = 1'b0;
  assign q_tile      = BACKGROUND;
  assign unused_bits = ^{pix_y[9], q_req, q_tx, q_ty, fsm_grant, fsm_addr, fsm_ack, fsm_tile};
`endif

  scene_query_fsm #(
    .SCENE_BLOCK_WIDTH (SCENE_BLOCK_WIDTH),
    .SCENE_BLOCK_HEIGHT(SCENE_BLOCK_HEIGHT),
    .ADDR_W            (ADDR_W)
  ) u_query (
    .clk          (clk),
    .rst          (rst),
    .generate_done(generate_done),
    .pix_active   (pix_active),
    .q_req        (fsm_req),
    .q_tx         (fsm_tx),
    .q_ty         (fsm_ty),
    .mem_data     (mem_data),
    .q_grant      (fsm_grant),
    .q_addr       (fsm_addr),
    .q_ack        (fsm_ack),
    .q_tile       (fsm_tile)
  );

  // Address stage: raster owns the port in active video, query FSM in blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
    end else if (query_owns) begin
      mem_addr <= fsm_addr;
    end else begin
      mem_addr <= raster_addr;
    end
  end

  // Offsets and valid ride alongside the read through wait and output stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_x1    <= '0;
      off_y1    <= '0;
      valid1    <= 1'b0;
      off_x2    <= '0;
      off_y2    <= '0;
      valid2    <= 1'b0;
      pix_tile  <= BACKGROUND;
      pix_off_x <= '0;
      pix_off_y <= '0;
      pix_valid <= 1'b0;
    end else begin
      off_x1    <= pix_x[TILE_SHIFT-1:0];
      off_y1    <= pix_y[TILE_SHIFT-1:0];
      valid1    <= pix_active;
      off_x2    <= off_x1;
      off_y2    <= off_y1;
      valid2    <= valid1;
      pix_tile  <= generate_done ? mem_data : BACKGROUND;
      pix_off_x <= off_x2;
      pix_off_y <= off_y2;
      pix_valid <= valid2;
    end
  end

endmodule
